cr_wb_arbiter: RTL
==================

# cr_wb_arbiter

Write-back arbiter that shares the single per-field condition-register write port among several execution units. Each unit presents one tagged CR result, covering any subset of the eight 4-bit CR fields. The arbiter grants requesters in round-robin order and can merge requesters with disjoint field masks into one cycle. It drives the CR file write port from a registered stage and sits between the unit result buses and the CR register file.

## Interface
- `RS_ID_WIDTH`, default 5: reservation-station tag width; matches the CR file.
- `NUM_UNITS`, default 4: number of requesting units, range 2..8.
- `clk` in, 1 bit: clock.
- `rst` in, 1 bit: reset. Asynchronous and active-high; one clock domain.
- `flush` in, 1 bit: synchronous kill of the acceptance and output stage.
- `req_valid[0:NUM_UNITS-1]` in, 1 bit each: unit result pending.
- `req_ready[0:NUM_UNITS-1]` out, 1 bit each: result accepted this cycle; combinational.
- `req_field_mask[0:NUM_UNITS-1]` in, 8 bits each: bit i set means CR field i is written (bit 0 = CR0).
- `req_value[0:NUM_UNITS-1]` in, 32 bits each: full CR image; only masked fields are used.
- `req_rs_id[0:NUM_UNITS-1]` in, RS_ID_WIDTH each: tag of the producing reservation station.
- `write_enable[0:7]` out, 1 bit each: registered; goes to the CR file.
- `write_value` out, 32 bits: registered.
- `write_rs_id[0:7]` out, RS_ID_WIDTH each: registered per-field tag.

## Operation
- Round-robin pointer `rr_ptr` (clog2(NUM_UNITS) bits) names the highest-priority unit.
- Scan order is rr_ptr, rr_ptr+1, … modulo NUM_UNITS.
- Each cycle the scan builds a claimed-field set, starting empty:
  - A valid unit is granted if its mask does not intersect the claimed set.
  - When a unit is granted, its mask is ORed into the claimed set.
- `req_ready[u]` equals the grant for unit u. A transfer happens when valid and ready are both high.
- Grant does not depend on `req_ready` from any other unit.
- A valid unit with an all-zero mask is always granted. It produces no write enables.
- The output register loads once per cycle:
  - `write_enable[i]` = field i is claimed.
  - `write_value[4i +: 4]` = the owning unit's `req_value[4i +: 4]`.
  - `write_rs_id[i]` = the owning unit's `req_rs_id`.
- Unclaimed fields: enable 0, value 0, rs_id 0.
- Pointer update: if any unit is granted, `rr_ptr` becomes (first granted unit in scan order) + 1 mod NUM_UNITS. Otherwise `rr_ptr` holds.
- Starvation bound: a continuously valid unit is granted within NUM_UNITS cycles.
- `flush` = 1:
  - All `req_ready` are forced to 0.
  - The output register loads all-zero.
  - `rr_ptr` holds.
  - A result that was registered in the previous cycle is still presented on the outputs this cycle. Flush only kills the load.
- Unit sources must keep `req_*` stable while valid and not ready. The arbiter does not check this.

## Timing
- Reset values: all `write_enable` = 0, `write_value` = 0, all `write_rs_id` = 0, `rr_ptr` = 0.
- During reset, `req_ready` = 0 combinationally.
- Latency: acceptance in cycle N produces a CR file write at the clk edge ending cycle N+1. Outputs are valid during cycle N+1.
- The outputs are a single-cycle pulse; they are not held.
- Throughput: up to one write per field per cycle. There is no backpressure from the CR file.
- Reset asserted mid-operation clears the outputs and pointer immediately. Pending unit results are not accepted until reset deasserts.
- Reset deassertion is synchronized externally.

## Configuration
- `CR_ARB_MERGE_EN` defined: disjoint-mask merging as described above; several grants per cycle are possible.
- Not defined: at most one grant per cycle, namely the first valid unit in scan order, whatever its mask. The claimed set is that unit's mask alone. Ports are unchanged.

## Structure
- Shared package `ppc_types` gains:
  - `CR_FIELDS = 8`.
  - Typedef `cr_field_mask_t` (logic[0:7]).
  - Typedef `cr_wb_req_t`, a struct of mask, value and rs_id.
- One sub-module, `cr_field_claim`: pure combinational scan from rr_ptr, valid and masks to grant vector, per-field owner index and first-grant index.
- The top level holds `rr_ptr`, the flush gating and the output register.

## Test plan
- Reset: assert rst mid-stream → all outputs and `req_ready` are 0 asynchronously; after release `rr_ptr` = 0.
- Single request: unit 1, mask 8'b1000_0000, value 32'hA000_0000, rs_id 5 → ready[1] = 1 in cycle N. In cycle N+1: write_enable[0] = 1, write_value[0:3] = 4'hA, write_rs_id[0] = 5, all other enables 0. rr_ptr = 2.
- Merge (macro on): units 0 and 2 with masks 8'hF0 and 8'h0F → both ready in one cycle. Next cycle all 8 enables are set, fields 0-3 tagged with unit 0's rs_id and fields 4-7 with unit 2's.
- Conflict and rotation: all 4 units with mask 8'h01, held valid → grants in order 0, 1, 2, 3, 0. Exactly one enable (field 7) per cycle.
- Macro off: repeat the merge stimulus → unit 0 granted in cycle N, unit 2 in cycle N+1.
- Flush: flush = 1 with unit 3 valid → ready[3] = 0, next-cycle enables all 0, rr_ptr unchanged. Unit 3 is accepted on the first cycle after flush drops.

Source files
------------

// File: rtl/cr_wb_arbiter_pkg.sv
// Shared CR write-back types: field masks, request bundle and nibble helper.
// Used by cr_wb_arbiter and cr_field_claim (optional merging: CR_ARB_MERGE_EN).
package ppc_types;

  localparam int CR_FIELDS = 8;
  localparam int CR_RS_ID_W = 5;

  typedef logic [0:7] cr_field_mask_t;

  typedef struct packed {
    cr_field_mask_t        mask;
    logic [0:31]           value;
    logic [CR_RS_ID_W-1:0] rs_id;
  } cr_wb_req_t;

  function automatic logic [0:3] cr_nibble(
    input logic [0:31] v,
    input int          f
  );
    return v[4*f +: 4];
  endfunction

endpackage

// File: rtl/cr_wb_arbiter_claim.sv
// Round-robin field-claim scan: grants, per-field owner, first grant.
// CR_ARB_MERGE_EN enables granting several units with disjoint masks.
module cr_field_claim
  import ppc_types::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int IW        = 2
) (
  input  logic [IW-1:0]        rr_ptr,
  input  logic [0:NUM_UNITS-1] valid,
  input  cr_field_mask_t       mask [NUM_UNITS],
  output logic [0:NUM_UNITS-1] grant,
  output logic [IW-1:0]        owner [CR_FIELDS],
  output cr_field_mask_t       claimed,
  output logic [IW-1:0]        first_idx,
  output logic                 any_grant
);

  int   u;
  logic take;

  always_comb begin
    grant     = '0;
    claimed   = '0;
    first_idx = '0;
    any_grant = 1'b0;
    u         = 0;
    take      = 1'b0;
    for (int f = 0; f < CR_FIELDS; f++) begin
      owner[f] = '0;
    end
    for (int k = 0; k < NUM_UNITS; k++) begin
      u = (int'(rr_ptr) + k) % NUM_UNITS;
`ifdef CR_ARB_MERGE_EN
      take = valid[u] && ((mask[u] & claimed) == '0);
`else
      take = valid[u] && !any_grant;
`endif
      if (take) begin
        grant[u] = 1'b1;
        claimed  = claimed | mask[u];
        for (int f = 0; f < CR_FIELDS; f++) begin
          if (mask[u][f]) begin
            owner[f] = IW'(u);
          end
        end
        if (!any_grant) begin
          first_idx = IW'(u);
        end
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_wb_arbiter.sv
// CR write-back arbiter: round-robin grant, flush gating, registered write port.
// Define CR_ARB_MERGE_EN to merge requesters with disjoint field masks.
module cr_wb_arbiter
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_UNITS   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [0:NUM_UNITS-1]   req_valid,
  output logic [0:NUM_UNITS-1]   req_ready,
  input  cr_field_mask_t         req_field_mask [NUM_UNITS],
  input  logic [0:31]            req_value [NUM_UNITS],
  input  logic [RS_ID_WIDTH-1:0] req_rs_id [NUM_UNITS],
  output logic [0:7]             write_enable,
  output logic [0:31]            write_value,
  output logic [RS_ID_WIDTH-1:0] write_rs_id [CR_FIELDS]
);

  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        next_ptr;
  logic [IW-1:0]        first_idx;
  logic [IW-1:0]        owner [CR_FIELDS];
  logic [0:NUM_UNITS-1] grant;
  cr_field_mask_t       claimed;
  logic                 any_grant;
  logic                 load;

  cr_field_claim #(
    .NUM_UNITS(NUM_UNITS),
    .IW       (IW)
  ) u_claim (
    .rr_ptr   (rr_ptr),
    .valid    (req_valid),
    .mask     (req_field_mask),
    .grant    (grant),
    .owner    (owner),
    .claimed  (claimed),
    .first_idx(first_idx),
    .any_grant(any_grant)
  );

  assign load      = !flush;
  assign req_ready = (rst || flush) ? '0 : grant;

  always_comb begin
    if (int'(first_idx) == NUM_UNITS - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = first_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      write_enable <= '0;
      write_value  <= '0;
      for (int f = 0; f < CR_FIELDS; f++) begin
        write_rs_id[f] <= '0;
      end
    end else begin
      if (load && any_grant) begin
        rr_ptr <= next_ptr;
      end
      write_enable <= load ? claimed : '0;
      // Unclaimed fields carry zero value and tag, not stale data.
      for (int f = 0; f < CR_FIELDS; f++) begin
        if (load && claimed[f]) begin
          write_value[4*f +: 4] <= cr_nibble(req_value[owner[f]], f);
          write_rs_id[f]        <= req_rs_id[owner[f]];
        end else begin
          write_value[4*f +: 4] <= 4'h0;
          write_rs_id[f]        <= '0;
        end
      end
    end
  end

endmodule
